psum_collector: RTL and testbench
=================================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter SIZE, default 8: array columns, and rows per tile.
REQ-002 SHALL have parameter PSUM_WIDTH, default 45 ((8*4)+4+SIZE+1): width of one bottom-row partial sum.
REQ-003 SHALL have parameter ACC_WIDTH, default PSUM_WIDTH+4: accumulator entry width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Start  input  1  one-cycle job start, sampled only in IDLE.
REQ-007 Tile_num  input  5  tiles to accumulate, sampled with Start; legal range 1..16.
REQ-008 Psum_in  input  SIZE*PSUM_WIDTH  bottom-row partial sums; column c at bits [c*PSUM_WIDTH +: PSUM_WIDTH].
REQ-009 Psum_in_valid  input  SIZE  per-column valid, driven from the bottom-row activation pass-valid; columns are skewed by one cycle each.
REQ-010 Out_data  output  SIZE*ACC_WIDTH  one accumulated result row; column c at bits [c*ACC_WIDTH +: ACC_WIDTH].
REQ-011 Out_valid  output  1  Out_data is valid.
REQ-012 Out_ready  input  1  consumer accepts Out_data.
REQ-013 Busy  output  1  high in ACCUM and DRAIN.
REQ-014 Done  output  1  one-cycle pulse after the last row is accepted.
REQ-015 Err  output  1  sticky protocol error flag.

Function
REQ-016 SHALL implement states IDLE, ACCUM and DRAIN.
REQ-017 IDLE->ACCUM on Start: latch Tile_num (value 0 is treated as 1), clear every column row pointer and tile count, clear Err.
REQ-018 SHALL keep a SIZE x SIZE accumulator buffer: entry [row][col].
REQ-019 ACCUM, for each column c with Psum_in_valid[c]=1 and tile count < Tile_num: entry [ptr_c][c] SHALL take the zero-extended psum if tile count_c=0, else the sum of the entry and the zero-extended psum; ptr_c SHALL then increment.
REQ-020 When ptr_c wraps from SIZE-1 to 0, tile count_c SHALL increment.
REQ-021 Columns SHALL be fully independent; any mix of columns valid in one cycle is legal.
REQ-022 ACCUM->DRAIN at the clock edge where the last column reaches tile count = Tile_num; Out_valid SHALL be high in the next cycle.
REQ-023 DRAIN: a drain pointer starts at row 0; Out_data SHALL present buffer row drain_ptr; Out_valid SHALL be high for the whole state.
REQ-024 A transfer SHALL occur only when Out_valid and Out_ready are both high; the pointer then advances; Out_data SHALL be held stable while Out_ready is low.
REQ-025 When row SIZE-1 transfers: DRAIN->IDLE, and Done SHALL pulse high for the following cycle.
REQ-026 Psum_in_valid[c] in IDLE or DRAIN, or after column c completed all tiles, SHALL be ignored and SHALL set Err.
REQ-027 Start outside IDLE SHALL be ignored and SHALL set Err.
REQ-028 Accumulation SHALL be unsigned; overflow SHALL follow REQ-033.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and clear all pointers, tile counts and Err.
REQ-030 During reset, Out_valid, Busy and Done SHALL be 0; Out_data SHALL be 0 (buffer cleared).
REQ-031 Reset during ACCUM or DRAIN SHALL abandon the job; no Done pulse SHALL be produced.

Configuration
REQ-032 Saturating accumulation SHALL be compiled in by macro PSUM_COLLECTOR_SAT_EN.
REQ-033 Macro defined: a sum exceeding 2^ACC_WIDTH-1 SHALL clamp to 2^ACC_WIDTH-1. Macro undefined: the sum SHALL wrap modulo 2^ACC_WIDTH.

Verification
REQ-034 Tile_num=1, SIZE=8, column c row r psum = 10*r+c, skewed valid, Out_ready=1 -> 8 rows out, row r col c = 10*r+c; Done pulse 1 cycle after row 7.
REQ-035 Tile_num=3, every psum=5 -> every output entry = 15; Busy high from the cycle after Start until the DRAIN->IDLE edge.
REQ-036 Out_ready toggling 1,0,0,1 during DRAIN -> each row held stable while stalled, no row skipped or repeated.
REQ-037 Psum_in_valid=8'h01 while IDLE, then Start during ACCUM -> Err=1 and remains 1 until the next accepted Start; accumulated data unaffected.
REQ-038 Tile_num=16, every psum = 2^PSUM_WIDTH-1 -> entry = 16*(2^PSUM_WIDTH-1); ACC_WIDTH=PSUM_WIDTH+1 variant -> clamped to all ones with PSUM_COLLECTOR_SAT_EN, wrapped value without it.
REQ-039 rst_n low mid-DRAIN after row 3 -> Out_valid=0 immediately, no Done; new Start with Tile_num=1 completes normally.

Source files
------------

// File: rtl/psum_collector.sv
// Collects skewed bottom-row partial sums into a SIZE x SIZE buffer over Tile_num tiles, then drains rows.
// Define PSUM_COLLECTOR_SAT_EN for saturating accumulation; otherwise sums wrap.
module psum_collector #(
    parameter int SIZE       = 8,
    parameter int PSUM_WIDTH = (8 * 4) + 4 + SIZE + 1,
    parameter int ACC_WIDTH  = PSUM_WIDTH + 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Start,
    input  logic [4:0]                 Tile_num,
    input  logic [SIZE*PSUM_WIDTH-1:0] Psum_in,
    input  logic [SIZE-1:0]            Psum_in_valid,
    output logic [SIZE*ACC_WIDTH-1:0]  Out_data,
    output logic                       Out_valid,
    input  logic                       Out_ready,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Err
);

    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(SIZE - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] buf_q [SIZE][SIZE];
    logic [PTR_W-1:0]     ptr_q [SIZE];
    logic [4:0]           tile_cnt_q [SIZE];
    logic [4:0]           tile_cnt_d [SIZE];
    logic [ACC_WIDTH-1:0] psum_ext [SIZE];
    logic [4:0]           tile_num_q;
    logic [PTR_W-1:0]     drain_ptr_q;
    logic                 err_q, done_q;
    logic [SIZE-1:0]      acc_en;
    logic                 all_done, start_ok, xfer, last_xfer, proto_err;

    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [ACC_WIDTH-1:0] b);
`ifdef PSUM_COLLECTOR_SAT_EN
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Per-column accept and next tile count; the job is complete once every column hits Tile_num.
    always_comb begin
        acc_en   = '0;
        all_done = 1'b1;
        for (int c = 0; c < SIZE; c++) begin
            psum_ext[c]   = ACC_WIDTH'(Psum_in[c*PSUM_WIDTH +: PSUM_WIDTH]);
            acc_en[c]     = (state_q == StAccum) && Psum_in_valid[c] &&
                            (tile_cnt_q[c] < tile_num_q);
            tile_cnt_d[c] = tile_cnt_q[c];
            if (acc_en[c] && (ptr_q[c] == LAST_ROW)) begin
                tile_cnt_d[c] = tile_cnt_q[c] + 5'd1;
            end
            if (tile_cnt_d[c] != tile_num_q) begin
                all_done = 1'b0;
            end
        end
    end

    assign start_ok  = (state_q == StIdle) && Start;
    assign xfer      = (state_q == StDrain) && Out_ready;
    assign last_xfer = xfer && (drain_ptr_q == LAST_ROW);
    // Any valid not consumed by accumulation is a protocol violation.
    assign proto_err = (Start && (state_q != StIdle)) || (|(Psum_in_valid & ~acc_en));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Start) state_d = StAccum;
            StAccum: if (all_done) state_d = StDrain;
            StDrain: if (last_xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_num_q  <= 5'd1;
            drain_ptr_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            for (int c = 0; c < SIZE; c++) begin
                ptr_q[c]      <= '0;
                tile_cnt_q[c] <= '0;
                for (int r = 0; r < SIZE; r++) begin
                    buf_q[r][c] <= '0;
                end
            end
        end else begin
            done_q <= last_xfer;
            if (start_ok) begin
                tile_num_q  <= (Tile_num == 5'd0) ? 5'd1 : Tile_num;
                drain_ptr_q <= '0;
                err_q       <= 1'b0;
                for (int c = 0; c < SIZE; c++) begin
                    ptr_q[c]      <= '0;
                    tile_cnt_q[c] <= '0;
                end
            end else begin
                if (proto_err) begin
                    err_q <= 1'b1;
                end
                if (xfer) begin
                    drain_ptr_q <= (drain_ptr_q == LAST_ROW) ? '0 : drain_ptr_q + PTR_W'(1);
                end
                for (int c = 0; c < SIZE; c++) begin
                    if (acc_en[c]) begin
                        // First tile overwrites, so stale data from a previous job never leaks in.
                        buf_q[ptr_q[c]][c] <= (tile_cnt_q[c] == 5'd0) ? psum_ext[c] :
                                              acc_add(buf_q[ptr_q[c]][c], psum_ext[c]);
                        ptr_q[c]      <= (ptr_q[c] == LAST_ROW) ? '0 : ptr_q[c] + PTR_W'(1);
                        tile_cnt_q[c] <= tile_cnt_d[c];
                    end
                end
            end
        end
    end

    always_comb begin
        Out_data = '0;
        for (int c = 0; c < SIZE; c++) begin
            Out_data[c*ACC_WIDTH +: ACC_WIDTH] = buf_q[drain_ptr_q][c];
        end
    end

    assign Out_valid = (state_q == StDrain);
    assign Busy      = (state_q != StIdle);
    assign Done      = done_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_psum_collector.sv
// Table-driven bench for psum_collector: accumulate/drain vectors plus error, stall and reset sequences.
module tb_psum_collector;

    localparam int SIZE = 8;
    localparam int PW   = 45;
    localparam int AW   = PW + 4;
    localparam int AW2  = PW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 Start = 1'b0;
    logic [4:0]           Tile_num = 5'd0;
    logic [SIZE*PW-1:0]   Psum_in = '0;
    logic [SIZE-1:0]      Psum_in_valid = '0;
    logic                 Out_ready = 1'b0;
    logic [SIZE*AW-1:0]   Out_data;
    logic                 Out_valid, Busy, Done, Err;
    logic [SIZE*AW2-1:0]  Out_data2;
    logic                 Out_valid2, Busy2, Done2, Err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psum_collector #(.SIZE(SIZE), .PSUM_WIDTH(PW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Tile_num(Tile_num), .Psum_in(Psum_in),
        .Psum_in_valid(Psum_in_valid), .Out_data(Out_data), .Out_valid(Out_valid),
        .Out_ready(Out_ready), .Busy(Busy), .Done(Done), .Err(Err)
    );

    // Narrow-accumulator instance used for the overflow vector.
    psum_collector #(.SIZE(SIZE), .PSUM_WIDTH(PW), .ACC_WIDTH(AW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Tile_num(Tile_num), .Psum_in(Psum_in),
        .Psum_in_valid(Psum_in_valid), .Out_data(Out_data2), .Out_valid(Out_valid2),
        .Out_ready(Out_ready), .Busy(Busy2), .Done(Done2), .Err(Err2)
    );

    typedef struct {
        logic [4:0]      tiles;
        int              mode;       // 0: 10*r+c, 1: constant 5, 2: all ones
        longint unsigned k;          // expected entry = k + rm*r + cm*c
        longint unsigned rm;
        longint unsigned cm;
        logic [3:0]      rdy;        // Out_ready pattern, bit (cycle % 4)
        bit              bad_start;
        logic            err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pval(input int mode, input int r, input int c);
        logic [PW-1:0] ones;
        ones = '1;
        case (mode)
            0:       return PW'(10 * r + c);
            1:       return PW'(5);
            default: return ones;
        endcase
    endfunction

    task automatic run_vec(input int vi, input int nrows);
        vec_t v;
        int eff, idx, cyc;
        bit stalled;
        logic [SIZE*AW-1:0] prev;
        longint unsigned e, e2;
        v = vecs[vi];
        eff = (v.tiles == 5'd0) ? 1 : int'(v.tiles);
`ifdef PSUM_COLLECTOR_SAT_EN
        e2 = (64'd1 << AW2) - 64'd1;
`else
        e2 = (64'd1 << AW2) - 64'd16;
`endif
        @(negedge clk);
        check($sformatf("v%0d busy_idle", vi), 64'(Busy), 64'd0);
        Start = 1'b1;
        Tile_num = v.tiles;
        @(negedge clk);
        check($sformatf("v%0d busy_after_start", vi), 64'(Busy), 64'd1);
        check($sformatf("v%0d err_after_start", vi), 64'(Err), 64'd0);
        for (int t = 0; t < 8 * eff + SIZE - 1; t++) begin
            Psum_in_valid = '0;
            Psum_in = '0;
            for (int c = 0; c < SIZE; c++) begin
                int k;
                k = t - c;
                if (k >= 0 && k < 8 * eff) begin
                    Psum_in_valid[c] = 1'b1;
                    Psum_in[c*PW +: PW] = pval(v.mode, k % 8, c);
                end
            end
            Start = v.bad_start && (t == 3);
            @(negedge clk);
        end
        Psum_in_valid = '0;
        Start = 1'b0;
        check($sformatf("v%0d drain_busy", vi), 64'(Busy), 64'd1);
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        prev = '0;
        while (idx < nrows && cyc < 64) begin
            Out_ready = v.rdy[cyc % 4];
            #1;
            check($sformatf("v%0d out_valid", vi), 64'(Out_valid), 64'd1);
            if (!Out_valid) break;
            if (stalled) check($sformatf("v%0d held row%0d", vi, idx), 64'(Out_data == prev), 64'd1);
            if (Out_ready) begin
                for (int c = 0; c < SIZE; c++) begin
                    e = v.k + v.rm * longint'(idx) + v.cm * longint'(c);
                    check($sformatf("v%0d row%0d col%0d", vi, idx, c),
                          64'(Out_data[c*AW +: AW]), e);
                    if (v.mode == 2) begin
                        check($sformatf("v%0d narrow row%0d col%0d", vi, idx, c),
                              64'(Out_data2[c*AW2 +: AW2]), e2);
                    end
                end
                idx++;
                stalled = 1'b0;
            end else begin
                prev = Out_data;
                stalled = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d rows_taken", vi), 64'(idx), 64'(nrows));
        if (nrows == SIZE) begin
            check($sformatf("v%0d done_pulse", vi), 64'(Done), 64'd1);
            check($sformatf("v%0d busy_end", vi), 64'(Busy), 64'd0);
            check($sformatf("v%0d valid_end", vi), 64'(Out_valid), 64'd0);
            if (v.mode == 2) begin
                check("narrow done", 64'(Done2), 64'd1);
                check("narrow err", 64'(Err2), 64'd0);
                check("narrow busy", 64'(Busy2), 64'd0);
                check("narrow valid", 64'(Out_valid2), 64'd0);
            end
            @(negedge clk);
            check($sformatf("v%0d done_cleared", vi), 64'(Done), 64'd0);
            check($sformatf("v%0d err_final", vi), 64'(Err), 64'(v.err));
        end
    endtask

    initial begin
        vecs[0] = '{5'd1,  0, 64'd0,  64'd10, 64'd1, 4'b1111, 1'b0, 1'b0};
        vecs[1] = '{5'd3,  1, 64'd15, 64'd0,  64'd0, 4'b1111, 1'b0, 1'b0};
        vecs[2] = '{5'd1,  0, 64'd0,  64'd10, 64'd1, 4'b1001, 1'b0, 1'b0};
        vecs[3] = '{5'd0,  1, 64'd5,  64'd0,  64'd0, 4'b1111, 1'b0, 1'b0};
        vecs[4] = '{5'd2,  0, 64'd0,  64'd20, 64'd2, 4'b1111, 1'b0, 1'b0};
        vecs[5] = '{5'd1,  0, 64'd0,  64'd10, 64'd1, 4'b1111, 1'b1, 1'b1};
        vecs[6] = '{5'd16, 2, 64'h1_FFFF_FFFF_FFF0, 64'd0, 64'd0, 4'b1111, 1'b0, 1'b0};

        #1;
        check("reset out_valid", 64'(Out_valid), 64'd0);
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset err", 64'(Err), 64'd0);
        check("reset out_data", 64'(|Out_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stray valid while idle raises Err, which stays until an accepted Start.
        @(negedge clk);
        Psum_in_valid = 8'h01;
        @(negedge clk);
        Psum_in_valid = '0;
        check("idle valid err", 64'(Err), 64'd1);
        repeat (3) @(negedge clk);
        check("idle err sticky", 64'(Err), 64'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, SIZE);
        end

        // Reset after row 3 of a drain abandons the job.
        run_vec(0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(Out_valid), 64'd0);
        check("midrst busy", 64'(Busy), 64'd0);
        check("midrst done", 64'(Done), 64'd0);
        check("midrst out_data", 64'(|Out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst no_done", 64'(Done), 64'd0);
        end
        run_vec(0, SIZE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
